// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
// Purpose: buffer entry layout and fixed constants used by fetch_buffer,
//          fetch_unit and anything modelling the instruction memory.
// Ports:   none (package).
package fetch_pkg;

  localparam int          FETCH_BUF_DEPTH   = 2;
  // Word the instruction memory returns for an address beyond its depth.
  localparam logic [31:0] FETCH_FAULT_INSTR = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch-to-decode valid/ready handshake bundle
// Purpose: carries the buffer head {pc, instr, fault} from fetch to decode.
// Signals: if_valid/if_pc/if_instr/if_fault driven by fetch (master),
//          if_ready driven by decode (slave).
interface fetch_if;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  modport master (
    output if_valid, if_pc, if_instr, if_fault,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_pc, if_instr, if_fault,
    output if_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry FIFO of fetched instructions with flush
// Purpose: holds returned instruction words until decode takes them. The head
//          entry lives in its own register so the outputs are pure flop outputs.
// Ports:   clk, reset (async, active-high)
//          push/push_data  write an entry at the edge
//          pop             consume the head at the edge (ignored when empty)
//          flush           drop every entry; overrides push/pop
//          count           current occupancy 0..2
//          head/head_valid registered head entry
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head,
  output logic         head_valid
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    pop_ok  = pop & (count_q != 2'd0);
    // Flush only clears occupancy; stale data stays in the slots but is
    // never presented because head_valid drops.
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_data;
          else                 slot1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            slot0_d = push_data;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign head       = slot0_q;
  assign head_valid = (count_q != 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, memory issue, return buffer
// Purpose: owns the PC, issues one word address per cycle to a memory with a
//          1-cycle registered read, captures the returned word into a 2-entry
//          buffer and presents the head to decode; redirect flushes and restarts.
// Ports:   clk, reset (async, active-high)
//          fetch_en                  allow new fetches
//          redirect_valid/redirect_pc flush and restart at redirect_pc
//          imem_addr/imem_rdata      instruction memory address / returned word
//          dec (fetch_if.master)     if_valid/if_ready/if_pc/if_instr/if_fault
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_SIZE  = 1024,
  parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  fetch_if.master     dec
);

  localparam logic [31:0] MEM_LIMIT   = 32'(MEM_SIZE);
  // Entries held plus words in flight after this cycle's pop must leave room
  // for the word about to be issued.
  localparam logic [2:0]  ISSUE_LIMIT = 3'(BUF_DEPTH - 1);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_q, inflight_d;

  logic [1:0]   occ;
  logic [2:0]   load;
  logic         pop;
  logic         push;
  logic         issue;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         head_valid;

  always_comb begin
    pop   = head_valid & dec.if_ready;
    load  = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    issue = fetch_en & ~redirect_valid & (load <= ISSUE_LIMIT);

    // A redirect kills the word returning this cycle.
    push             = inflight_q & ~redirect_valid;
    push_entry.pc    = inflight_pc_q;
    push_entry.instr = imem_rdata;
    push_entry.fault = (inflight_pc_q >= MEM_LIMIT);

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= 32'h0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (occ),
    .head       (head),
    .head_valid (head_valid)
  );

  assign imem_addr    = fetch_pc_q;
  assign dec.if_valid = head_valid;
  assign dec.if_pc    = head.pc;
  assign dec.if_instr = head.instr;
  assign dec.if_fault = head.fault;

endmodule
